// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: byte/half/word loads and stores against a word-only memory,
// with read-modify-write for sub-word stores, load extension and misalignment rejection.
module dm_access_ctrl #(
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd,
  output logic [31:0] mem_pc
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

  state_t      state;
  logic        lat_we;
  logic        lat_unsigned;
  logic [1:0]  lat_size;
  logic [1:0]  lat_offset;
  logic [15:0] lat_wdata;
  logic [2:0]  wait_cnt;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = offset[0];
      2'b10:   bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] offset, input logic uns);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   result = {{24{lane_b[7] & ~uns}}, lane_b};
      2'b01:   result = {{16{lane_h[15] & ~uns}}, lane_h};
      default: result = word;
    endcase
    return result;
  endfunction

  // Only the addressed lane is replaced; every other bit keeps the value just read.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] offset, input logic [15:0] data);
    logic [31:0] result;
    result = word;
    if (size == 2'b00) begin
      case (offset)
        2'd0:    result[7:0]   = data[7:0];
        2'd1:    result[15:8]  = data[7:0];
        2'd2:    result[23:16] = data[7:0];
        default: result[31:24] = data[7:0];
      endcase
    end else if (offset[1]) begin
      result[31:16] = data;
    end else begin
      result[15:0] = data;
    end
    return result;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      mem_addr     <= '0;
      mem_wd       <= '0;
      mem_we       <= 1'b0;
      mem_pc       <= '0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= '0;
      lat_offset   <= '0;
      lat_wdata    <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          mem_we    <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready    <= 1'b0;
            lat_we       <= req_we;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_offset   <= req_addr[1:0];
            lat_wdata    <= req_wdata[15:0];
            mem_pc       <= req_pc;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              resp_err <= 1'b0;
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_we && (req_size == 2'b10)) begin
                mem_wd <= req_wdata;
                mem_we <= 1'b1;
                state  <= WR;
              end else begin
                wait_cnt <= LAT_INIT;
                state    <= RD;
              end
            end
          end
        end

        RD: begin
          if (wait_cnt == 3'd0) begin
            if (lat_we) begin
              mem_wd <= store_merge(mem_rd, lat_size, lat_offset, lat_wdata);
              mem_we <= 1'b1;
              state  <= WR;
            end else begin
              resp_rdata <= load_extract(mem_rd, lat_size, lat_offset, lat_unsigned);
              resp_valid <= 1'b1;
              state      <= RESP;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        WR: begin
          mem_we     <= 1'b0;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          // req_ready rises with the take so the next accept lands on the following edge.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: two instances (RD_LATENCY 0 and 3) share stimulus, each with its own
// word memory; a reference memory model predicts read data, merged store words and latencies.
module tb_dm_access_ctrl;

  localparam int LAT_A = 0;
  localparam int LAT_B = 3;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat_a;
    int          lat_b;
    int          pulses;
    logic [31:0] waddr;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_ready;

  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wd     [2];
  logic        mem_we     [2];
  logic [31:0] mem_rd     [2];
  logic [31:0] mem_pc     [2];

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] ref_mem [64];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  int          we_cnt [2];
  logic [31:0] last_waddr [2];
  logic [31:0] last_wd [2];
  logic [31:0] last_pc [2];

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  dm_access_ctrl #(.RD_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_addr(mem_addr[0]), .mem_wd(mem_wd[0]), .mem_we(mem_we[0]),
    .mem_rd(mem_rd[0]), .mem_pc(mem_pc[0])
  );

  dm_access_ctrl #(.RD_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_addr(mem_addr[1]), .mem_wd(mem_wd[1]), .mem_we(mem_we[1]),
    .mem_rd(mem_rd[1]), .mem_pc(mem_pc[1])
  );

  assign mem_rd[0] = mem_a[mem_addr[0][7:2]];
  assign mem_rd[1] = mem_b[mem_addr[1][7:2]];

  // Word memories: backdoor preload plus the controllers' write strobes.
  always @(posedge clk) begin
    if (pre_en) begin
      mem_a[pre_idx] <= pre_data;
      mem_b[pre_idx] <= pre_data;
    end
    if (mem_we[0]) mem_a[mem_addr[0][7:2]] <= mem_wd[0];
    if (mem_we[1]) mem_b[mem_addr[1][7:2]] <= mem_wd[1];
  end

  // Write-strobe monitor: each cycle with mem_we high is one pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_we[i]) begin
        we_cnt[i]     = we_cnt[i] + 1;
        last_waddr[i] = mem_addr[i];
        last_wd[i]    = mem_wd[i];
        last_pc[i]    = mem_pc[i];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] data);
    pre_en   = 1'b1;
    pre_idx  = 6'(idx);
    pre_data = data;
    ref_mem[idx] = data;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  function automatic exp_t predict(input string tag, input logic we, input logic [1:0] size,
                                   input logic uns, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] pc);
    exp_t e;
    logic [31:0] word, mask, lane;
    int sh;
    e.tag = tag; e.rdata = '0; e.err = 1'b0; e.pulses = 0;
    e.waddr = {addr[31:2], 2'b00}; e.wd = '0; e.pc = pc;
    word = ref_mem[addr[7:2]];
    sh = (size == 2'b00) ? 8 * int'(addr[1:0]) : 16 * int'(addr[1]);
    mask = (size == 2'b00) ? (32'hFF << sh) : (32'hFFFF << sh);
    if ((size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)) begin
      e.err = 1'b1; e.lat_a = 1; e.lat_b = 1;
    end else if (we) begin
      e.pulses = 1;
      if (size == 2'b10) begin
        e.wd = wdata; e.lat_a = 2; e.lat_b = 2;
      end else begin
        e.wd = (word & ~mask) | ((wdata << sh) & mask);
        e.lat_a = 3 + LAT_A; e.lat_b = 3 + LAT_B;
      end
    end else begin
      e.lat_a = 2 + LAT_A; e.lat_b = 2 + LAT_B;
      if (size == 2'b10) begin
        e.rdata = word;
      end else begin
        lane = (word & mask) >> sh;
        if (!uns && size == 2'b00 && lane[7])  lane = lane | 32'hFFFF_FF00;
        if (!uns && size == 2'b01 && lane[15]) lane = lane | 32'hFFFF_0000;
        e.rdata = lane;
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold);
    exp_t e;
    int base[2], lat[2], k, guard;
    logic [31:0] first_rd[2];
    pc_ctr = pc_ctr + 32'd4;
    e = predict(tag, we, size, uns, addr, wdata, pc_ctr);
    exp_q.push_back(e);
    if (e.pulses != 0) ref_mem[addr[7:2]] = (size == 2'b10) ? wdata : e.wd;
    base[0] = we_cnt[0]; base[1] = we_cnt[1];

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_pc = pc_ctr;
    guard = 0;
    while (!(req_ready[0] && req_ready[1]) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_ready"}, {30'b0, req_ready[1], req_ready[0]}, 32'd3);
    @(posedge clk);
    #1 req_valid = 1'b0;

    // k counts edges after the accept edge; a response visible right after it is latency 1.
    lat[0] = -1; lat[1] = -1; k = 0;
    while ((lat[0] < 0 || lat[1] < 0) && k < 30) begin
      for (int i = 0; i < 2; i++) begin
        if (resp_valid[i] && lat[i] < 0) begin
          lat[i] = k + 1;
          first_rd[i] = resp_rdata[i];
        end
      end
      @(posedge clk);
      #1 k++;
    end

    repeat (hold) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, {30'b0, resp_valid[1], resp_valid[0]}, 32'd3);
      checkOutput({tag, "_hold_rdata_b"}, resp_rdata[1], first_rd[1]);
      checkOutput({tag, "_hold_ready"}, {30'b0, req_ready[1], req_ready[0]}, 32'd0);
    end

    e = exp_q.pop_front();
    checkOutput({e.tag, "_lat_a"}, 32'(lat[0]), 32'(e.lat_a));
    checkOutput({e.tag, "_lat_b"}, 32'(lat[1]), 32'(e.lat_b));
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s_rdata%0d", e.tag, i), resp_rdata[i], e.rdata);
      checkOutput($sformatf("%s_err%0d", e.tag, i), {31'b0, resp_err[i]}, {31'b0, e.err});
      checkOutput($sformatf("%s_pulses%0d", e.tag, i), 32'(we_cnt[i] - base[i]), 32'(e.pulses));
      if (e.pulses != 0) begin
        checkOutput($sformatf("%s_waddr%0d", e.tag, i), last_waddr[i], e.waddr);
        checkOutput($sformatf("%s_wd%0d", e.tag, i), last_wd[i], e.wd);
        checkOutput($sformatf("%s_wpc%0d", e.tag, i), last_pc[i], e.pc);
      end
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    checkOutput({e.tag, "_taken"}, {30'b0, resp_valid[1], resp_valid[0]}, 32'd0);
  endtask

  task automatic resetDuringRead();
    int base[2];
    base[0] = we_cnt[0]; base[1] = we_cnt[1];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h42; req_wdata = 32'h7777; req_pc = 32'h2000;
    checkOutput("rst_pre_ready", {30'b0, req_ready[1], req_ready[0]}, 32'd3);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_flags%0d", i),
                  {28'b0, resp_valid[i], mem_we[i], req_ready[i], resp_err[i]}, 32'd0);
      checkOutput($sformatf("rst_data%0d", i),
                  mem_addr[i] | mem_wd[i] | mem_pc[i] | resp_rdata[i], 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rst_no_write_a", 32'(we_cnt[0] - base[0]), 32'd0);
    checkOutput("rst_no_write_b", 32'(we_cnt[1] - base[1]), 32'd0);
    applyStimulus("rst_lw_after", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_pc = '0; resp_ready = 1'b0;
    pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    we_cnt[0] = 0; we_cnt[1] = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    preload(8, 32'h1122_3344);
    preload(12, 32'h8000_F0FF);
    preload(16, 32'hCAFE_F00D);

    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset_flags%0d", i),
                  {28'b0, resp_valid[i], mem_we[i], req_ready[i], resp_err[i]}, 32'd0);
      checkOutput($sformatf("reset_data%0d", i),
                  mem_addr[i] | mem_wd[i] | mem_pc[i] | resp_rdata[i], 32'd0);
    end
    @(negedge clk) reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    applyStimulus("sw_10",      1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    applyStimulus("sb_22",      1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 0);
    applyStimulus("lw_20",      1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);
    applyStimulus("lb_30",      1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 0);
    applyStimulus("lbu_30",     1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 0);
    applyStimulus("lb_31",      1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 0);
    applyStimulus("lh_32",      1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 0);
    applyStimulus("lhu_32",     1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 0);
    applyStimulus("lhu_30",     1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 0);
    applyStimulus("lw_05_mis",  1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 0);
    applyStimulus("sh_07_mis",  1'b1, 2'b01, 1'b0, 32'h07, 32'h1234, 0);
    applyStimulus("size11",     1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 0);
    applyStimulus("sh_31_mis",  1'b1, 2'b01, 1'b0, 32'h31, 32'h5678, 0);
    applyStimulus("lw_10_bp",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    applyStimulus("sh_12",      1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234, 0);
    applyStimulus("lw_10_post", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    applyStimulus("sb_33",      1'b1, 2'b00, 1'b0, 32'h33, 32'hFFFF_FF5A, 0);
    applyStimulus("lbu_33",     1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 0);
    applyStimulus("sw_high",    1'b1, 2'b10, 1'b0, 32'hA000_0014, 32'h55AA_55AA, 0);
    applyStimulus("lw_14",      1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0);
    resetDuringRead();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
